// File: rtl/icu_fetch_queue.sv
// Instruction fetch stage: walks a PC through synchronous imem and buffers words in a credit-managed FIFO.
// Optional macro ICU_FETCH_PERF_CNT_EN adds saturating fetched/stall counters.
module icu_fetch_queue #(
    parameter int INSTR_WIDTH          = 32,
    parameter int INSTR_MEM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_addr,
    input  logic                            flush,
    output logic                            imem_req,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [INSTR_WIDTH-1:0]          imem_rdata,
    output logic                            instr_valid,
    output logic [INSTR_WIDTH-1:0]          instr_out,
    input  logic                            instr_ready,
    output logic                            busy,
`ifdef ICU_FETCH_PERF_CNT_EN
    output logic [31:0]                     fetched_count,
    output logic [31:0]                     stall_count,
`endif
    output logic                            halted
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t                          r_state;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] r_pc;
    logic                            r_inflight;
    logic [INSTR_WIDTH-1:0]          r_mem [FIFO_DEPTH];
    logic [PW-1:0]                   r_wptr;
    logic [PW-1:0]                   r_rptr;
    logic [CW-1:0]                   r_count;

    logic [CW-1:0] w_credit;
    logic [7:0]    w_respOp;
    logic          w_req;
    logic          w_resp;
    logic          w_push;
    logic          w_halt;
    logic          w_pop;

    // A request is only issued when the word it returns is guaranteed a FIFO slot.
    assign w_credit = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_req    = (r_state == S_FETCH) && (w_credit < CW'(FIFO_DEPTH));
    assign w_respOp = imem_rdata[INSTR_WIDTH-1 -: 8];
    assign w_resp   = (r_state == S_FETCH) && r_inflight;
    assign w_push   = w_resp && (w_respOp != 8'hFF);
    assign w_halt   = w_resp && (w_respOp == 8'hFF);
    assign w_pop    = (r_count != '0) && instr_ready;

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr_out   = r_mem[r_rptr];
    assign busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign halted      = (r_state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) r_pc <= r_pc + 1'b1;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc    <= start_addr;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_halt) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The request issued alongside the HALT return must land before we report halted.
                    if ((r_count == '0) && !r_inflight) r_state <= S_HALTED;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= imem_rdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == CW'(FIFO_DEPTH))));

`ifdef ICU_FETCH_PERF_CNT_EN
    logic [31:0] r_fetchedCount;
    logic [31:0] r_stallCount;

    // Counters survive flush on purpose; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchedCount <= '0;
            r_stallCount   <= '0;
        end else begin
            if (w_pop && (r_fetchedCount != '1)) r_fetchedCount <= r_fetchedCount + 1'b1;
            if (instr_valid && !instr_ready && (r_stallCount != '1))
                r_stallCount <= r_stallCount + 1'b1;
        end
    end

    assign fetched_count = r_fetchedCount;
    assign stall_count   = r_stallCount;
`endif

endmodule

// File: tb/tb_icu_fetch_queue.sv
// Bench for icu_fetch_queue: cycle table for a straight-line program, hand-written corner sequences,
// and randomized programs checked against a queue model of the expected instruction stream.
module tb_icu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic        flush;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        instr_ready;
    logic        busy;
    logic        halted;
`ifdef ICU_FETCH_PERF_CNT_EN
    logic [31:0] fetchedCount;
    logic [31:0] stallCount;
`endif

    icu_fetch_queue #(
        .INSTR_WIDTH(32),
        .INSTR_MEM_ADDR_WIDTH(10),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .flush(flush),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_out(instr_out),
        .instr_ready(instr_ready),
        .busy(busy),
`ifdef ICU_FETCH_PERF_CNT_EN
        .fetched_count(fetchedCount),
        .stall_count(stallCount),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous memory; returns garbage when not read so stray captures get noticed.
    logic [31:0] imem [1024];
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem[imem_addr];
        else          imem_rdata <= $urandom;
    end

    typedef struct {
        logic        start;
        logic        expReq;
        logic [9:0]  expAddr;
        logic        expValid;
        logic        chkOut;
        logic [31:0] expOut;
        logic        expBusy;
        logic        expHalted;
    } vec_t;

    vec_t        straight [11];
    int          vectors;
    int          miscompares;
    logic [31:0] gotQ [$];
    logic [31:0] expQ [$];
    int          stallSeen;

    function automatic vec_t mkVec(logic st, logic rq, logic [9:0] ad, logic vl, logic co,
                                   logic [31:0] ou, logic bz, logic hl);
        vec_t v;
        v.start = st; v.expReq = rq; v.expAddr = ad; v.expValid = vl;
        v.chkOut = co; v.expOut = ou; v.expBusy = bz; v.expHalted = hl;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        start       = v.start;
        start_addr  = 10'd5;
        flush       = 1'b0;
        instr_ready = 1'b1;
        checkOutput($sformatf("row%0d_req", idx), {31'b0, imem_req}, {31'b0, v.expReq});
        checkOutput($sformatf("row%0d_addr", idx), {22'b0, imem_addr}, {22'b0, v.expAddr});
        checkOutput($sformatf("row%0d_valid", idx), {31'b0, instr_valid}, {31'b0, v.expValid});
        if (v.chkOut) checkOutput($sformatf("row%0d_out", idx), instr_out, v.expOut);
        checkOutput($sformatf("row%0d_busy", idx), {31'b0, busy}, {31'b0, v.expBusy});
        checkOutput($sformatf("row%0d_halted", idx), {31'b0, halted}, {31'b0, v.expHalted});
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; instr_ready = 1'b1; start_addr = '0;
        tick();
        tick();
    endtask

    task automatic pulseStart(input logic [9:0] sa);
        start_addr = sa;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall the first three valid cycles
    task automatic collect(input int mode, input int budget, input logic chkAddr, input logic [9:0] sa);
        int         n;
        logic [9:0] expAddr;
        n = 0;
        stallSeen = 0;
        expAddr = sa;
        while (!halted && n < budget) begin
            case (mode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = ($urandom_range(0, 3) != 0);
                default: instr_ready = !(instr_valid && stallSeen < 3);
            endcase
            if (chkAddr && imem_req) begin
                checkOutput("reqAddr", {22'b0, imem_addr}, {22'b0, expAddr});
                expAddr = expAddr + 10'd1;
            end
            if (instr_valid && instr_ready) gotQ.push_back(instr_out);
            if (instr_valid && !instr_ready) stallSeen++;
            tick();
            n++;
        end
        instr_ready = 1'b1;
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL haltTimeout: got halted=%0b expected 1 within %0d cycles", halted, budget);
        end
    endtask

    task automatic compareQueues(input string name);
        checkOutput({name, "_len"}, gotQ.size(), expQ.size());
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_w%0d", name, i), gotQ[i], expQ[i]);
    endtask

    // Reference model: the stream is every word from start_addr up to, not including, the first HALT.
    task automatic buildExpected(input logic [9:0] sa);
        logic [9:0] a;
        expQ.delete();
        a = sa;
        for (int i = 0; i < 1024; i++) begin
            if (imem[a][31:24] == 8'hFF) break;
            expQ.push_back(imem[a]);
            a = a + 10'd1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         reqs;
        int         len;
        logic [9:0] sa;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) imem[i] = $urandom & 32'hFEFF_FFFF;

        // Straight-line program
        for (int i = 5; i <= 9; i++) imem[i] = 32'h0300_0421;
        imem[10] = 32'hFF00_0000;
        straight[0]  = mkVec(1, 0, 10'd0,  0, 1, 32'h0,         0, 0);
        straight[1]  = mkVec(0, 1, 10'd5,  0, 1, 32'h0,         1, 0);
        straight[2]  = mkVec(0, 1, 10'd6,  0, 1, 32'h0,         1, 0);
        straight[3]  = mkVec(0, 1, 10'd7,  1, 1, 32'h0300_0421, 1, 0);
        straight[4]  = mkVec(0, 1, 10'd8,  1, 1, 32'h0300_0421, 1, 0);
        straight[5]  = mkVec(0, 1, 10'd9,  1, 1, 32'h0300_0421, 1, 0);
        straight[6]  = mkVec(0, 1, 10'd10, 1, 1, 32'h0300_0421, 1, 0);
        straight[7]  = mkVec(0, 1, 10'd11, 1, 1, 32'h0300_0421, 1, 0);
        straight[8]  = mkVec(0, 0, 10'd12, 0, 0, 32'h0,         1, 0);
        straight[9]  = mkVec(0, 0, 10'd12, 0, 0, 32'h0,         1, 0);
        straight[10] = mkVec(0, 0, 10'd12, 0, 0, 32'h0,         0, 1);

        doReset();
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_addr", {22'b0, imem_addr}, 32'd0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_out", instr_out, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_halted", {31'b0, halted}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(straight[i], i);
            tick();
        end
        start = 1'b0;

        // Backpressure: exactly FIFO_DEPTH requests, then in-order release
        for (int i = 40; i <= 45; i++) imem[i] = 32'h0100_0000 | i;
        imem[46] = 32'hFF00_0046;
        instr_ready = 1'b0;
        pulseStart(10'd40);
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) reqs++;
            tick();
        end
        checkOutput("bp_reqCount", reqs, 32'd4);
        checkOutput("bp_reqStopped", {31'b0, imem_req}, 32'd0);
        checkOutput("bp_valid", {31'b0, instr_valid}, 32'd1);
        gotQ.delete();
        collect(0, 100, 1'b0, 10'd0);
        expQ = '{32'h0100_0028, 32'h0100_0029, 32'h0100_002A, 32'h0100_002B, 32'h0100_002C, 32'h0100_002D};
        compareQueues("bp");

        // Address wrap-around
        imem[1022] = 32'h0200_03FE;
        imem[1023] = 32'h0200_03FF;
        imem[0]    = 32'h0200_0000;
        imem[1]    = 32'hFF00_0001;
        gotQ.delete();
        pulseStart(10'd1022);
        collect(0, 100, 1'b0, 10'd0);
        expQ = '{32'h0200_03FE, 32'h0200_03FF, 32'h0200_0000};
        compareQueues("wrap");

        // Flush mid-stream, with a start that must be ignored in the flush cycle
        for (int i = 60; i <= 75; i++) imem[i] = 32'h0600_0000 | i;
        for (int i = 20; i <= 22; i++) imem[i] = 32'h0700_0000 | i;
        imem[23] = 32'hFF00_0023;
        instr_ready = 1'b1;
        pulseStart(10'd60);
        repeat (5) tick();
        checkOutput("fl_reqBefore", {31'b0, imem_req}, 32'd1);
        flush = 1'b1; start = 1'b1; start_addr = 10'd200;
        tick();
        flush = 1'b0; start = 1'b0;
        checkOutput("fl_valid7", {31'b0, instr_valid}, 32'd0);
        checkOutput("fl_busy7", {31'b0, busy}, 32'd0);
        checkOutput("fl_req7", {31'b0, imem_req}, 32'd0);
        tick();
        checkOutput("fl_valid8", {31'b0, instr_valid}, 32'd0);
        checkOutput("fl_halted8", {31'b0, halted}, 32'd0);
        gotQ.delete();
        pulseStart(10'd20);
        collect(0, 100, 1'b0, 10'd0);
        expQ = '{32'h0700_0014, 32'h0700_0015, 32'h0700_0016};
        compareQueues("flRestart");

        // Restart from HALTED; a second start during FETCH must not move the PC
        for (int i = 30; i <= 32; i++) imem[i] = 32'h0800_0000 | i;
        imem[33] = 32'hFF00_0033;
        imem[100] = 32'h0900_0064;
        imem[101] = 32'hFF00_0101;
        checkOutput("rs_haltedBefore", {31'b0, halted}, 32'd1);
        gotQ.delete();
        pulseStart(10'd30);
        checkOutput("rs_haltedCleared", {31'b0, halted}, 32'd0);
        tick();
        pulseStart(10'd100);
        collect(0, 100, 1'b0, 10'd0);
        expQ = '{32'h0800_001E, 32'h0800_001F, 32'h0800_0020};
        compareQueues("rs");

        // Randomized programs with random backpressure
        for (int run = 0; run < 15; run++) begin
            sa  = 10'($urandom_range(0, 1023));
            len = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) imem[10'(sa + k)] = $urandom & 32'hFEFF_FFFF;
            imem[10'(sa + len)] = 32'hFF00_0000 | $urandom_range(0, 255);
            buildExpected(sa);
            gotQ.delete();
            pulseStart(sa);
            collect(1, 400, 1'b1, sa);
            compareQueues($sformatf("rnd%0d", run));
            checkOutput($sformatf("rnd%0d_busy", run), {31'b0, busy}, 32'd0);
        end

`ifdef ICU_FETCH_PERF_CNT_EN
        // Performance counters: five pops with three stall cycles, then rst clears them
        for (int i = 200; i <= 204; i++) imem[i] = 32'h0A00_0000 | i;
        imem[205] = 32'hFF00_0205;
        doReset();
        rst = 1'b0;
        gotQ.delete();
        pulseStart(10'd200);
        collect(2, 100, 1'b0, 10'd0);
        checkOutput("perf_fetched", fetchedCount, 32'd5);
        checkOutput("perf_stall", stallCount, 32'd3);
        rst = 1'b1;
        tick();
        checkOutput("perf_fetchedRst", fetchedCount, 32'd0);
        checkOutput("perf_stallRst", stallCount, 32'd0);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
